uart_tx_buffer: RTL and testbench

//   Transmit-side character FIFO that sits directly upstream of the UART serial transmitter.
//   - Accepts bytes from the peripheral/register interface.
//   - Buffers up to FIFO_DEPTH of them.
//   - Feeds them one at a time over the transmitter's tx_enable/tx_ready handshake.
//   - Lets software queue a burst without polling per character.
//

---
 rtl/uart_pkg.sv | 5 +
 rtl/uart_tx_buffer_if.sv | 20 ++
 rtl/sync_fifo.sv | 49 ++++
 rtl/uart_tx_buffer.sv | 50 +++++
 tb/tb_uart_tx_buffer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared ASCII constants for the UART transmit path
package uart_pkg;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
endpackage

// File: rtl/uart_tx_buffer_if.sv
// uart_tx_buffer_if: write-side and transmitter-side signals of the TX buffer
//   wr_en/wr_data           byte push from the register interface
//   fifo_full/empty/count   occupancy status
//   tx_ready/tx_enable/char transmitter handshake
//   master drives pushes and tx_ready; slave is the buffer itself
interface uart_tx_buffer_if #(parameter int FIFO_DEPTH = 8);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   logic          wr_en;
   logic [7:0]    wr_data;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          tx_ready;
   logic          tx_enable;
   logic [7:0]    tx_char;
   modport master (output wr_en, wr_data, tx_ready,
                   input  fifo_full, fifo_empty, fifo_count, tx_enable, tx_char);
   modport slave  (input  wr_en, wr_data, tx_ready,
                   output fifo_full, fifo_empty, fifo_count, tx_enable, tx_char);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two storage array with wrapping pointers and an occupancy count
//   clk, reset      clock, asynchronous active-high reset
//   push, wr_data   write request and data (ignored while full)
//   pop, rd_data    read request (ignored while empty) and head entry
//   count/full/empty occupancy, all derived from registered state
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;
   always_comb begin
      full    = count == CW'(DEPTH);
      empty   = count == '0;
      do_push = push && !full;
      do_pop  = pop && !empty;
      rd_data = mem[rd_ptr];
   end
   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end
endmodule

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: transmit character FIFO feeding the UART serial transmitter
//   clk, reset  clock, asynchronous active-high reset
//   bus         uart_tx_buffer_if.slave: wr_en/wr_data push, fifo_full/fifo_empty/
//               fifo_count status, tx_ready in, tx_enable/tx_char out
//   `UART_TX_CRLF_EN: when defined, each LF is sent as CR followed by LF
module uart_tx_buffer
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic            clk,
   input  logic            reset,
   uart_tx_buffer_if.slave bus
);
   logic [7:0] head;
   logic       pop;
   logic       empty;
   sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (bus.wr_en),
      .wr_data (bus.wr_data),
      .pop     (pop),
      .rd_data (head),
      .count   (bus.fifo_count),
      .full    (bus.fifo_full),
      .empty   (empty)
   );
   assign bus.fifo_empty = empty;
   assign bus.tx_enable  = !empty && bus.tx_ready;
`ifdef UART_TX_CRLF_EN
   logic cr_pending;
   logic expand;
   // An LF head is offered first as CR without popping; cr_pending then lets the LF through.
   always_comb begin
      expand      = head == ASCII_LF && !cr_pending;
      bus.tx_char = empty ? 8'h00 : expand ? ASCII_CR : head;
      pop         = bus.tx_enable && !expand;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cr_pending <= 1'b0;
      else if (bus.tx_enable) cr_pending <= expand;
   end
`else
   always_comb begin
      bus.tx_char = empty ? 8'h00 : head;
      pop         = bus.tx_enable;
   end
`endif
endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: directed self-checking bench for uart_tx_buffer
module tb_uart_tx_buffer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   uart_tx_buffer_if #(.FIFO_DEPTH(8)) bus ();
   uart_tx_buffer #(.FIFO_DEPTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.tx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      bus.tx_ready = 1'b1;
      #1;
      checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bus.fifo_empty); end
      checks++; if (bus.fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.fifo_full); end
      checks++; if (bus.fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.fifo_count); end
      checks++; if (bus.tx_enable !== 1'b0) begin errors++; $display("FAIL reset_tx_enable got %b want 0", bus.tx_enable); end
      checks++; if (bus.tx_char !== 8'h00) begin errors++; $display("FAIL reset_tx_char got %h want 00", bus.tx_char); end
   endtask

   task automatic test_single();
      bus.wr_en = 1'b1; bus.wr_data = 8'h41; bus.tx_ready = 1'b1;
      #1;
      checks++; if (bus.tx_enable !== 1'b0) begin errors++; $display("FAIL single_bypass got %b want 0", bus.tx_enable); end
      step();
      bus.wr_en = 1'b0;
      #1;
      checks++; if (bus.tx_enable !== 1'b1) begin errors++; $display("FAIL single_enable got %b want 1", bus.tx_enable); end
      checks++; if (bus.tx_char !== 8'h41) begin errors++; $display("FAIL single_char got %h want 41", bus.tx_char); end
      step();
      #1;
      checks++; if (bus.tx_enable !== 1'b0) begin errors++; $display("FAIL single_one_cycle got %b want 0", bus.tx_enable); end
      checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL single_empty got %b want 1", bus.fifo_empty); end
   endtask

   task automatic test_fill_drop();
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.wr_en = 1'b1; bus.wr_data = 8'h10 + 8'(i);
         step();
      end
      bus.wr_en = 1'b1; bus.wr_data = 8'h99;
      #1;
      checks++; if (bus.fifo_full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", bus.fifo_full); end
      checks++; if (bus.fifo_count !== 4'd8) begin errors++; $display("FAIL fill_count got %0d want 8", bus.fifo_count); end
      step();
      bus.wr_en = 1'b0;
      #1;
      checks++; if (bus.fifo_count !== 4'd8) begin errors++; $display("FAIL drop_count got %0d want 8", bus.fifo_count); end
      bus.tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         checks++; if (bus.tx_enable !== 1'b1 || bus.tx_char !== 8'h10 + 8'(i)) begin errors++; $display("FAIL drain_%0d got en=%b char=%h want en=1 char=%h", i, bus.tx_enable, bus.tx_char, 8'h10 + 8'(i)); end
         step();
      end
      #1;
      checks++; if (bus.fifo_empty !== 1'b1 || bus.tx_enable !== 1'b0) begin errors++; $display("FAIL drain_end got empty=%b en=%b want 1 0", bus.fifo_empty, bus.tx_enable); end
   endtask

   task automatic test_full_push_pop();
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         bus.wr_en = 1'b1; bus.wr_data = 8'h20 + 8'(i);
      end
      step();
      bus.wr_en = 1'b1; bus.wr_data = 8'hEE; bus.tx_ready = 1'b1;
      #1;
      checks++; if (bus.tx_enable !== 1'b1 || bus.tx_char !== 8'h20) begin errors++; $display("FAIL pp_offer got en=%b char=%h want 1 20", bus.tx_enable, bus.tx_char); end
      step();
      bus.wr_en = 1'b0; bus.tx_ready = 1'b0;
      #1;
      checks++; if (bus.fifo_count !== 4'd7) begin errors++; $display("FAIL pp_count got %0d want 7", bus.fifo_count); end
      bus.tx_ready = 1'b1;
      for (int i = 1; i < 8; i++) begin
         #1;
         checks++; if (bus.tx_enable !== 1'b1 || bus.tx_char !== 8'h20 + 8'(i)) begin errors++; $display("FAIL pp_drain_%0d got en=%b char=%h want en=1 char=%h", i, bus.tx_enable, bus.tx_char, 8'h20 + 8'(i)); end
         step();
      end
      #1;
      checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL pp_empty got %b want 1", bus.fifo_empty); end
   endtask

   task automatic test_wrap_stream();
      int n_push = 0;
      int n_rx = 0;
      int busy = 0;
      for (int cyc = 0; cyc < 400 && n_rx < 20; cyc++) begin
         bus.tx_ready = busy == 0;
         bus.wr_en = n_push < 20 && !bus.fifo_full;
         bus.wr_data = 8'h50 + 8'(n_push);
         #1;
         if (bus.tx_enable) begin
            checks++; if (bus.tx_char !== 8'h50 + 8'(n_rx)) begin errors++; $display("FAIL stream_%0d got %h want %h", n_rx, bus.tx_char, 8'h50 + 8'(n_rx)); end
            n_rx++;
            busy = 3;
         end else if (busy > 0) busy--;
         if (bus.wr_en) n_push++;
         step();
      end
      bus.wr_en = 1'b0;
      checks++; if (n_rx !== 20) begin errors++; $display("FAIL stream_total got %0d want 20", n_rx); end
   endtask

   task automatic test_crlf();
      bus.tx_ready = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'h0A;
      step();
      bus.wr_en = 1'b0;
      #1;
`ifdef UART_TX_CRLF_EN
      checks++; if (bus.tx_enable !== 1'b1 || bus.tx_char !== 8'h0D) begin errors++; $display("FAIL crlf_cr got en=%b char=%h want 1 0d", bus.tx_enable, bus.tx_char); end
      step();
      #1;
      checks++; if (bus.fifo_count !== 4'd1) begin errors++; $display("FAIL crlf_count got %0d want 1", bus.fifo_count); end
      checks++; if (bus.tx_enable !== 1'b1 || bus.tx_char !== 8'h0A) begin errors++; $display("FAIL crlf_lf got en=%b char=%h want 1 0a", bus.tx_enable, bus.tx_char); end
      step();
      #1;
      checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL crlf_empty got %b want 1", bus.fifo_empty); end
      bus.wr_en = 1'b1; bus.wr_data = 8'h0D;
      step();
      bus.wr_en = 1'b0;
      #1;
      checks++; if (bus.tx_enable !== 1'b1 || bus.tx_char !== 8'h0D) begin errors++; $display("FAIL cr_verbatim got en=%b char=%h want 1 0d", bus.tx_enable, bus.tx_char); end
      step();
      #1;
      checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL cr_single got %b want 1", bus.fifo_empty); end
`else
      checks++; if (bus.tx_enable !== 1'b1 || bus.tx_char !== 8'h0A) begin errors++; $display("FAIL lf_pass got en=%b char=%h want 1 0a", bus.tx_enable, bus.tx_char); end
      step();
      #1;
      checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL lf_empty got %b want 1", bus.fifo_empty); end
`endif
   endtask

   task automatic test_reset_mid();
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.wr_en = 1'b1; bus.wr_data = (i == 0) ? 8'h0A : 8'h30 + 8'(i);
         step();
      end
      bus.wr_en = 1'b0;
`ifdef UART_TX_CRLF_EN
      bus.tx_ready = 1'b1;
      step();
      bus.tx_ready = 1'b0;
`endif
      #1;
      checks++; if (bus.fifo_count !== 4'd3) begin errors++; $display("FAIL mid_count got %0d want 3", bus.fifo_count); end
      reset = 1'b1;
      #1;
      checks++; if (bus.fifo_empty !== 1'b1 || bus.fifo_count !== 4'd0) begin errors++; $display("FAIL mid_reset got empty=%b count=%0d want 1 0", bus.fifo_empty, bus.fifo_count); end
      bus.tx_ready = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (bus.tx_enable !== 1'b0) begin errors++; $display("FAIL mid_idle_%0d got %b want 0", i, bus.tx_enable); end
         step();
      end
      bus.wr_en = 1'b1; bus.wr_data = 8'h0A;
      step();
      bus.wr_en = 1'b0;
      #1;
`ifdef UART_TX_CRLF_EN
      checks++; if (bus.tx_char !== 8'h0D) begin errors++; $display("FAIL mid_cr_cleared got %h want 0d", bus.tx_char); end
`else
      checks++; if (bus.tx_char !== 8'h0A) begin errors++; $display("FAIL mid_lf got %h want 0a", bus.tx_char); end
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_drop();
      test_full_push_pop();
      test_wrap_stream();
      test_crlf();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
